// File: rtl/egcd_pkg.sv
// Shared constants, coefficient type and FSM encoding for the extended-Euclid unit.
package egcd_pkg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 9;
  localparam int unsigned SW = CW + 1;

  typedef logic signed [SW-1:0] coef_t;
  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StCheck = 3'd1;
  localparam state_t StDiv   = 3'd2;
  localparam state_t StUpd   = 3'd3;
  localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/udiv_restoring.sv
// W-bit unsigned restoring divider, one quotient bit per cycle.
// The first bit is resolved on the go edge so ready pulses W cycles after launch.
module udiv_restoring
  import egcd_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         ready
);

  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         active_q, active_d, ready_q, ready_d;

  logic [W-1:0] in_rem, in_quo, in_dvs, sub, step_rem, step_quo;
  logic [W:0]   shifted;
  logic         fits;

  always_comb begin
    in_rem  = go ? '0 : rem_q;
    in_quo  = go ? dividend : quo_q;
    in_dvs  = go ? divisor : dvs_q;
    shifted = {in_rem, in_quo[W-1]};
    fits    = shifted >= {1'b0, in_dvs};
    // When fits, the true difference is below the divisor, so W bits suffice.
    sub      = shifted[W-1:0] - in_dvs;
    step_rem = fits ? sub : shifted[W-1:0];
    step_quo = {in_quo[W-2:0], fits};

    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    ready_d  = 1'b0;
    if (go) begin
      rem_d    = step_rem;
      quo_d    = step_quo;
      dvs_d    = divisor;
      cnt_d    = 4'(W - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d    = step_rem;
      quo_d    = step_quo;
      cnt_d    = cnt_q - 4'd1;
      ready_d  = (cnt_q == 4'd1);
      active_d = (cnt_q != 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      ready_q  <= ready_d;
    end
  end

  assign quo   = quo_q;
  assign rem   = rem_q;
  assign ready = ready_q;

endmodule

// File: rtl/egcd_seq.sv
// Sequential extended Euclid: gcd plus Bezout coefficients with start/busy/done.
// Define EGCD_MODINV_EN to add the inv/inv_valid modular-inverse outputs.
module egcd_seq
  import egcd_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  u,
  input  logic [W-1:0]  v,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  g,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
`ifdef EGCD_MODINV_EN
  ,
  output logic [W-1:0]  inv,
  output logic          inv_valid
`endif
);

  state_t        state_q, state_d;
  logic [W-1:0]  r0_q, r0_d, r1_q, r1_d;
  coef_t         s0_q, s0_d, s1_q, s1_d, t0_q, t0_d, t1_q, t1_d;
  logic [W-1:0]  g_q, g_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          done_q, done_d;

  logic          div_go, div_ready;
  logic [W-1:0]  div_quo, div_rem;
  logic [SW-1:0] q_ext, qs, qt;

`ifdef EGCD_MODINV_EN
  logic [W-1:0]  v_q, v_d, inv_q, inv_d, inv_sum;
  logic          inv_valid_q, inv_valid_d;
`endif

  udiv_restoring u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (div_go),
    .dividend (r0_q),
    .divisor  (r1_q),
    .quo      (div_quo),
    .rem      (div_rem),
    .ready    (div_ready)
  );

  // Low SW bits of the product only depend on the low SW bits of the operands.
  assign q_ext = {{(SW - W){1'b0}}, div_quo};
  assign qs    = q_ext * s1_q;
  assign qt    = q_ext * t1_q;

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    g_d     = g_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    div_go  = 1'b0;
`ifdef EGCD_MODINV_EN
    v_d         = v_q;
    inv_d       = inv_q;
    inv_valid_d = inv_valid_q;
    inv_sum     = s0_q[W-1:0] + v_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          r0_d    = u;
          r1_d    = v;
          s0_d    = coef_t'(1);
          s1_d    = '0;
          t0_d    = '0;
          t1_d    = coef_t'(1);
`ifdef EGCD_MODINV_EN
          v_d     = v;
`endif
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (r1_q == '0) begin
          state_d = StDone;
        end else begin
          div_go  = 1'b1;
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (div_ready) state_d = StUpd;
      end
      StUpd: begin
        r0_d    = r1_q;
        r1_d    = div_rem;
        s0_d    = s1_q;
        s1_d    = s0_q - coef_t'(qs);
        t0_d    = t1_q;
        t1_d    = t0_q - coef_t'(qt);
        state_d = StCheck;
      end
      StDone: begin
        g_d     = r0_q;
        x_d     = s0_q[CW-1:0];
        y_d     = t0_q[CW-1:0];
        done_d  = 1'b1;
`ifdef EGCD_MODINV_EN
        if (r0_q == W'(1) && v_q > W'(1)) begin
          inv_d       = s0_q[SW-1] ? inv_sum : s0_q[W-1:0];
          inv_valid_d = 1'b1;
        end else begin
          inv_d       = '0;
          inv_valid_d = (r0_q == W'(1)) && (v_q == W'(1));
        end
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r0_q    <= '0;
      r1_q    <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      g_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      g_q     <= g_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

`ifdef EGCD_MODINV_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q         <= '0;
      inv_q       <= '0;
      inv_valid_q <= 1'b0;
    end else begin
      v_q         <= v_d;
      inv_q       <= inv_d;
      inv_valid_q <= inv_valid_d;
    end
  end

  assign inv       = inv_q;
  assign inv_valid = inv_valid_q;
`endif

  // done is registered while the FSM is already back in IDLE, so it extends busy.
  assign busy = (state_q != StIdle) || done_q;
  assign done = done_q;
  assign g    = g_q;
  assign x    = x_q;
  assign y    = y_q;

endmodule
